// File: rtl/weight_stream_ctrl.sv
// weight_stream_ctrl: sweeps the coefficient ROM NUM_PASSES times per start
// and feeds the layer's weight FIFO through a 2-entry buffer. The buffer hides
// the ROM's one-cycle read latency and lets the stream stop under backpressure
// without losing or repeating a word.
module weight_stream_ctrl #(
    parameter int MEM_SIZE   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PASSES = 1,
    parameter int AW         = $clog2(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    output logic                  idle,
    output logic                  done,
    output logic [AW-1:0]         weight_address,
    output logic                  weight_ce,
    input  logic [DATA_WIDTH-1:0] weight_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    localparam int            PW        = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_SIZE - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [PW-1:0]           pass_q, pass_d;
    logic [1:0]              count_q, count_d;
    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;

    logic                    pop;
    logic                    bypass;
    logic                    pop_buf;
    logic                    push_buf;
    logic                    last_rd;
    logic [1:0]              occ;

    // Read issue, output strobe and buffer next-state.
    // A word returning from the ROM into an empty buffer is presented at the
    // head in the same cycle, so a free-flowing stream writes one cycle after
    // each read and never parks a word.
    always_comb begin
        output_V_write = ((count_q != 2'd0) || inflight_q) && output_V_full_n;
        output_V_din   = ((count_q == 2'd0) && inflight_q) ? weight_q : buf0_q;
        pop            = output_V_write;

        // Budget: buffered + in flight, less what leaves this cycle, stays <= 2.
        weight_ce = (state_q == S_RUN) &&
                    (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        last_rd   = weight_ce && (addr_q == ADDR_LAST) && (pass_q == PASS_LAST);

        bypass   = pop && (count_q == 2'd0);
        pop_buf  = pop && (count_q != 2'd0);
        push_buf = inflight_q && !bypass;

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ    = count_q;
        if (pop_buf) begin
            buf0_d = buf1_q;
            occ    = count_q - 2'd1;
        end
        if (push_buf) begin
            if (occ == 2'd0) buf0_d = weight_q;
            else             buf1_d = weight_q;
        end
        count_d = occ + {1'b0, push_buf};
    end

    // Sequencer FSM and address/pass counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        idle    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            S_RUN: begin
                if (last_rd) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // No read issues here, so nothing is in flight next cycle;
                // leave once the buffer will be empty.
                if (count_d == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (weight_ce) begin
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                if (pass_q != PASS_LAST) pass_d = pass_q + PW'(1);
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end
    end

    assign weight_address = addr_q;

    // State, counters, in-flight flag and buffer registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            count_q    <= count_d;
            inflight_q <= weight_ce;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl with MEM_SIZE=4, NUM_PASSES=2 and a
// ROM holding mem[a] = 0x10 + a. Cycle 0 of each test is the cycle in which
// the first start pulse is driven.
module tb_weight_stream_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        start;
    logic        idle;
    logic        done;
    logic [1:0]  weight_address;
    logic        weight_ce;
    logic [15:0] weight_q = 16'h0;
    logic [15:0] output_V_din;
    logic        output_V_full_n;
    logic        output_V_write;

    int checks = 0;
    int errors = 0;

    logic start_tab [64];
    logic fulln_tab [64];
    logic rstn_tab  [64];

    logic        ce_log   [64];
    logic        wr_log   [64];
    logic        idle_log [64];
    logic [15:0] din_log  [64];
    logic [1:0]  adr_log  [64];

    int          ce_cyc [$];
    int          ce_adr [$];
    int          wr_cyc [$];
    logic [15:0] wr_dat [$];
    int          done_cyc [$];
    int          max_held;

    weight_stream_ctrl #(
        .MEM_SIZE  (4),
        .DATA_WIDTH(16),
        .NUM_PASSES(2)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .start          (start),
        .idle           (idle),
        .done           (done),
        .weight_address (weight_address),
        .weight_ce      (weight_ce),
        .weight_q       (weight_q),
        .output_V_din   (output_V_din),
        .output_V_full_n(output_V_full_n),
        .output_V_write (output_V_write)
    );

    always #5 ap_clk = ~ap_clk;

    // ROM model: one-cycle read latency.
    always @(posedge ap_clk) begin
        if (weight_ce) weight_q <= 16'h10 + {14'd0, weight_address};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_tabs();
        for (int c = 0; c < 64; c++) begin
            start_tab[c] = 1'b0;
            fulln_tab[c] = 1'b1;
            rstn_tab[c]  = 1'b1;
        end
    endtask

    // Entered just after a rising edge; drives one table row per cycle and
    // samples on the falling edge.
    task automatic run_test(input int ncyc);
        ce_cyc.delete();
        ce_adr.delete();
        wr_cyc.delete();
        wr_dat.delete();
        done_cyc.delete();
        max_held = 0;
        for (int c = 0; c < ncyc; c++) begin
            start           = start_tab[c];
            output_V_full_n = fulln_tab[c];
            ap_rst_n        = rstn_tab[c];
            @(negedge ap_clk);
            ce_log[c]   = weight_ce;
            wr_log[c]   = output_V_write;
            idle_log[c] = idle;
            din_log[c]  = output_V_din;
            adr_log[c]  = weight_address;
            if (weight_ce) begin
                ce_cyc.push_back(c);
                ce_adr.push_back(int'(weight_address));
            end
            if (output_V_write) begin
                wr_cyc.push_back(c);
                wr_dat.push_back(output_V_din);
            end
            if (done) done_cyc.push_back(c);
            if (ce_cyc.size() - wr_cyc.size() > max_held)
                max_held = ce_cyc.size() - wr_cyc.size();
            @(posedge ap_clk);
            #1;
        end
        start           = 1'b0;
        output_V_full_n = 1'b1;
        ap_rst_n        = 1'b1;
    endtask

    // Written words must be 0x10..0x13 repeated, nothing missing or doubled.
    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_nwr"}, wr_dat.size(), n);
        for (int i = 0; i < wr_dat.size() && i < n; i++)
            chk({tag, "_data"}, {16'h0, wr_dat[i]}, 32'h10 + (i % 4));
    endtask

    function automatic int wc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction

    function automatic int dc(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -1;
    endfunction

    initial begin
        int stall_cyc [8];
        int ce_early;

        ap_rst_n        = 1'b0;
        start           = 1'b0;
        output_V_full_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_idle",  idle, 1);
        chk("rst_done",  done, 0);
        chk("rst_ce",    weight_ce, 0);
        chk("rst_write", output_V_write, 0);
        chk("rst_addr",  weight_address, 0);
        chk("rst_din",   output_V_din, 0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Free flow.
        clear_tabs();
        start_tab[0] = 1'b1;
        run_test(14);
        chk_seq("free", 8);
        for (int i = 0; i < 8; i++) chk("free_wcyc", wc(i), 2 + i);
        chk("free_ndone",  done_cyc.size(), 1);
        chk("free_donecyc", dc(0), 10);
        chk("free_idle10", idle_log[10], 0);
        chk("free_idle11", idle_log[11], 1);
        chk("free_nce",    ce_cyc.size(), 8);
        chk("free_ce0",    (ce_cyc.size() > 0) ? ce_cyc[0] : -1, 1);

        // Mid-stream stall, full_n low in cycles 4..8.
        clear_tabs();
        start_tab[0] = 1'b1;
        for (int c = 4; c <= 8; c++) fulln_tab[c] = 1'b0;
        run_test(20);
        chk_seq("stall", 8);
        stall_cyc = '{2, 3, 9, 10, 11, 12, 13, 14};
        for (int i = 0; i < 8; i++) chk("stall_wcyc", wc(i), stall_cyc[i]);
        chk("stall_held",    max_held, 2);
        chk("stall_din6",    din_log[6], 16'h12);
        chk("stall_donecyc", dc(0), 15);
        chk("stall_ndone",   done_cyc.size(), 1);

        // Stall from the cycle after start, released at cycle 10.
        clear_tabs();
        start_tab[0] = 1'b1;
        for (int c = 1; c <= 9; c++) fulln_tab[c] = 1'b0;
        run_test(24);
        ce_early = 0;
        for (int c = 0; c <= 9; c++) if (ce_log[c]) ce_early++;
        chk("sfs_nce",  ce_early, 2);
        chk("sfs_adr0", (ce_adr.size() > 0) ? ce_adr[0] : -1, 0);
        chk("sfs_adr1", (ce_adr.size() > 1) ? ce_adr[1] : -1, 1);
        chk("sfs_din3", din_log[3], 16'h10);
        chk("sfs_din9", din_log[9], 16'h10);
        chk_seq("sfs", 8);
        chk("sfs_wcyc0",   wc(0), 10);
        chk("sfs_donecyc", dc(0), 18);

        // Extra start pulses while busy and in DONE are ignored.
        clear_tabs();
        start_tab[0]  = 1'b1;
        start_tab[3]  = 1'b1;
        start_tab[10] = 1'b1;
        run_test(16);
        chk_seq("restart", 8);
        chk("restart_ndone",   done_cyc.size(), 1);
        chk("restart_donecyc", dc(0), 10);
        chk("restart_nce",     ce_cyc.size(), 8);
        chk("restart_idle12",  idle_log[12], 1);

        // Reset mid-run, then a fresh run.
        clear_tabs();
        start_tab[0] = 1'b1;
        rstn_tab[5]  = 1'b0;
        rstn_tab[6]  = 1'b0;
        run_test(12);
        chk("rrun_nwr_pre", wr_cyc.size(), 3);
        chk("rrun_idle5",   idle_log[5], 1);
        chk("rrun_ce5",     ce_log[5], 0);
        chk("rrun_wr5",     wr_log[5], 0);
        chk("rrun_din5",    din_log[5], 0);
        chk("rrun_adr5",    adr_log[5], 0);
        chk("rrun_ndone",   done_cyc.size(), 0);
        clear_tabs();
        start_tab[0] = 1'b1;
        run_test(14);
        chk_seq("rrun_fresh", 8);
        chk("rrun_donecyc", dc(0), 10);

        // Back-to-back: second start in the cycle idle returns high.
        clear_tabs();
        start_tab[0]  = 1'b1;
        start_tab[11] = 1'b1;
        run_test(26);
        chk_seq("b2b", 16);
        chk("b2b_wcyc8", wc(8), 13);
        chk("b2b_ndone", done_cyc.size(), 2);
        chk("b2b_done0", dc(0), 10);
        chk("b2b_done1", dc(1), 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
